// File: rtl/pgz_pkg.sv
// Shared widths and state encodings for the pgz byte packer.
package pgz_pkg;

    localparam int WORD_W         = 81;
    localparam int BYTES_PER_WORD = 11;
    localparam int TAG_W          = 6;
    localparam int CNT_W          = 4;

    typedef enum logic {
        ASM_IDLE = 1'b0,
        ASM_FILL = 1'b1
    } asm_state_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/pgz_hold_reg.sv
// One-entry output register for a word and its tag.
// It can drain and reload on the same edge without a bubble.
module pgz_hold_reg
    import pgz_pkg::*;
#(
    parameter logic [TAG_W-1:0] RST_TAG = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [TAG_W-1:0]  load_tag,
    input  logic              out_ready,
    output logic              state,
    output logic [WORD_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag
);

    out_state_t        state_q, state_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        tag_d   = tag_q;
        case (state_q)
            OUT_EMPTY: if (load) state_d = OUT_FULL;
            OUT_FULL:  if (!load && out_ready) state_d = OUT_EMPTY;
            default:   state_d = OUT_EMPTY;
        endcase
        if (load) begin
            data_d = load_data;
            tag_d  = load_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= OUT_EMPTY;
            data_q  <= '0;
            tag_q   <= RST_TAG;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign state    = state_q;
    assign out_data = data_q;
    assign out_tag  = tag_q;

endmodule

// File: rtl/pgz_byte_packer.sv
// Packs 11 LSB-first bytes into an 81-bit word with a rolling 6-bit tag.
// Resync on in_sof, flush discards the partial word, pad bits are optionally checked.
module pgz_byte_packer
    import pgz_pkg::*;
#(
    parameter logic [5:0] TAG_INIT  = 6'd0,
    parameter int         PAD_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_sof,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [80:0] pgzvid,
    output logic [5:0]  kdyziobqu,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        resync_err,
    output logic        pad_err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

    asm_state_t                       asm_state_q, asm_state_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [8*(BYTES_PER_WORD-1)-1:0]  acc_q, acc_d;
    logic [TAG_W-1:0]                 tag_q, tag_d;
    logic                             resync_q, resync_d;
    logic                             pad_q, pad_d;
    logic                             load;
    logic                             accept;
    logic                             hold_state;

    // Valid/ready: a transfer happens on a rising edge where both are high on
    // the same side; only the final byte can stall, and only while the held word
    // is not being taken, so a drain and the next load may share one edge.
    assign in_ready = !(count_q == LAST_IDX && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        count_d  = count_q;
        acc_d    = acc_q;
        tag_d    = tag_q;
        resync_d = 1'b0;
        pad_d    = 1'b0;
        load     = 1'b0;
        if (flush) begin
            count_d = '0;
        end else if (accept) begin
            if (in_sof && asm_state_q == ASM_FILL) begin
                acc_d[7:0] = in_byte;
                count_d    = CNT_W'(1);
                resync_d   = 1'b1;
            end else if (count_q == LAST_IDX) begin
                load    = 1'b1;
                count_d = '0;
                tag_d   = tag_q + 1'b1;
                pad_d   = (PAD_CHECK != 0) && (|in_byte[7:1]);
            end else begin
                for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
                    if (count_q == CNT_W'(k)) acc_d[8*k +: 8] = in_byte;
                end
                count_d = count_q + 1'b1;
            end
        end
        asm_state_d = (count_d == '0) ? ASM_IDLE : ASM_FILL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_state_q <= ASM_IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            tag_q       <= TAG_INIT;
            resync_q    <= 1'b0;
            pad_q       <= 1'b0;
        end else begin
            asm_state_q <= asm_state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            tag_q       <= tag_d;
            resync_q    <= resync_d;
            pad_q       <= pad_d;
        end
    end

    // Only bit 0 of the last byte lands in the word; bits 7:1 are padding.
    pgz_hold_reg #(
        .RST_TAG (TAG_INIT)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data ({in_byte[0], acc_q}),
        .load_tag  (tag_q),
        .out_ready (out_ready),
        .state     (hold_state),
        .out_data  (pgzvid),
        .out_tag   (kdyziobqu)
    );

    assign out_valid  = (hold_state == OUT_FULL);
    assign resync_err = resync_q;
    assign pad_err    = pad_q;

endmodule
